mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAX_STARVE, default 4, consecutive fetch-losing cycles before fetch wins one contended grant.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 i_req_valid  in  1 / i_req_addr  in  32: fetch request, held stable until accepted.
REQ-005 i_req_ready  out  1: fetch request accepted this cycle.
REQ-006 i_rsp_valid  out  1 / i_rsp_data  out  32: fetch read data, one-cycle pulse.
REQ-007 d_req_valid  in  1 / d_req_addr  in  32 / d_req_wdata  in  32 / d_req_we  in  1 / d_req_be  in  4: data request, held stable until accepted.
REQ-008 d_req_ready  out  1: data request accepted this cycle.
REQ-009 d_rsp_valid  out  1 / d_rsp_data  out  32: data read data or write acknowledge, one-cycle pulse.
REQ-010 mem_en  out  1 / mem_addr  out  32 / mem_wdata  out  32 / mem_we  out  1 / mem_be  out  4: single shared memory port.
REQ-011 mem_rdata  in  32: memory read data, valid the cycle after mem_en.

Function
REQ-012 Accept = req_valid and req_ready in the same cycle; at most one requester accepted per cycle.
REQ-013 Acceptance drives mem_en=1 and the winner's address/wdata/we/be onto mem_* in that cycle; otherwise mem_en=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
REQ-014 Fetch requests force mem_we=0 and mem_be=4'b1111.
REQ-015 Response latency exactly 1 cycle: the winner's rsp_valid pulses high the cycle after acceptance, carrying mem_rdata.
REQ-016 Data writes return d_rsp_valid=1 with d_rsp_data=0.
REQ-017 No response backpressure; requesters must accept rsp_valid when presented.
REQ-018 Throughput one request per cycle; a new acceptance in the same cycle as the previous response is allowed.
REQ-019 FSM states IDLE, RESP_I, RESP_D: IDLE/RESP_x -> RESP_I on fetch accept, -> RESP_D on data accept, -> IDLE on no accept.
REQ-020 Only one requester valid: it wins that cycle.
REQ-021 Both valid: data wins unless starve_cnt == MAX_STARVE, in which case fetch wins.
REQ-022 starve_cnt increments when fetch is valid and not accepted, saturates at MAX_STARVE, and clears on fetch accept.
REQ-023 starve_cnt holds when i_req_valid=0.
REQ-024 Ready outputs are combinational from current valids and starve_cnt; the loser's ready is 0.
REQ-025 A requester deasserting valid before acceptance is legal; no memory access is issued for it.

Reset
REQ-026 While rst_n=0 at a clock edge: state=IDLE, starve_cnt=0, all rsp_valid=0, rsp_data=0.
REQ-027 While rst_n=0, i_req_ready=0, d_req_ready=0, mem_en=0.
REQ-028 Reset mid-operation discards the outstanding response; no rsp_valid in the cycle after reset.

Structure
REQ-029 Shared package mem_arb_pkg holds the state enum, the owner enum (OWN_NONE, OWN_I, OWN_D) and the default MAX_STARVE constant.
REQ-030 One sub-module, mem_arb_grant, holds the combinational priority/starvation grant logic; the FSM, counter and response registers stay in mem_arbiter.

Verification
REQ-031 Fetch only, addr 0x00000004, mem_rdata 0x00500093 next cycle -> i_req_ready same cycle, i_rsp_valid=1, i_rsp_data=0x00500093 one cycle later, d_rsp_valid stays 0.
REQ-032 Data write addr 0x100, wdata 0xDEADBEEF, be 4'b0011 -> mem_we=1, mem_be=4'b0011, mem_wdata=0xDEADBEEF; next cycle d_rsp_valid=1, d_rsp_data=0.
REQ-033 Both valid continuously, MAX_STARVE=4 -> grants D,D,D,D,I,D,D,D,D,I...; starve_cnt returns to 0 after each I grant.
REQ-034 Back-to-back fetches 0x0, 0x4, 0x8 -> three consecutive accepts, three consecutive i_rsp_valid pulses with matching data, no gap cycles.
REQ-035 rst_n low in the cycle after a data accept -> d_rsp_valid stays 0, all readies 0, state IDLE, starve_cnt 0.
REQ-036 i_req_valid pulsed for one cycle while data wins, then dropped -> no fetch mem_en, no i_rsp_valid, starve_cnt holds at 1.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the fetch/data memory arbiter
// Contents: state_t (FSM states), owner_t (grant owner), DEFAULT_MAX_STARVE.
package mem_arb_pkg;

  localparam int DEFAULT_MAX_STARVE = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP_I = 2'd1,
    RESP_D = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

endpackage

// File: rtl/mem_arb_grant.sv
// rtl/mem_arb_grant.sv - combinational priority/starvation grant selection
// Ports:
//   i_valid    in  fetch request valid
//   d_valid    in  data request valid
//   starve_cnt in  consecutive cycles fetch has been valid and lost
//   owner      out requester granted this cycle (OWN_NONE when idle)
module mem_arb_grant
  import mem_arb_pkg::*;
#(
  parameter int MAX_STARVE = DEFAULT_MAX_STARVE,
  parameter int CNT_W      = $clog2(MAX_STARVE + 1)
) (
  input  logic             i_valid,
  input  logic             d_valid,
  input  logic [CNT_W-1:0] starve_cnt,
  output owner_t           owner
);

  logic starved;
  assign starved = (starve_cnt == CNT_W'(MAX_STARVE));

  // Data has priority; fetch takes one contended grant once it has been starved.
  always_comb begin
    owner = OWN_NONE;
    if (i_valid && d_valid) begin
      owner = starved ? OWN_I : OWN_D;
    end else if (i_valid) begin
      owner = OWN_I;
    end else if (d_valid) begin
      owner = OWN_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter onto one single-cycle memory port
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   i_req_valid/addr, i_req_ready    fetch request handshake
//   i_rsp_valid/data                 fetch read response, one cycle after accept
//   d_req_valid/addr/wdata/we/be,
//   d_req_ready                      data request handshake
//   d_rsp_valid/data                 data read response or write ack (data 0)
//   mem_en/addr/wdata/we/be          shared memory command, driven in accept cycle
//   mem_rdata                        memory read data, valid cycle after mem_en
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_STARVE = DEFAULT_MAX_STARVE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_valid,
  input  logic [31:0] i_req_addr,
  output logic        i_req_ready,
  output logic        i_rsp_valid,
  output logic [31:0] i_rsp_data,
  input  logic        d_req_valid,
  input  logic [31:0] d_req_addr,
  input  logic [31:0] d_req_wdata,
  input  logic        d_req_we,
  input  logic [3:0]  d_req_be,
  output logic        d_req_ready,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_data,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_STARVE + 1);

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic             d_was_write;
  owner_t           grant;
  owner_t           owner;

  mem_arb_grant #(
    .MAX_STARVE (MAX_STARVE),
    .CNT_W      (CNT_W)
  ) u_grant (
    .i_valid    (i_req_valid),
    .d_valid    (d_req_valid),
    .starve_cnt (starve_cnt),
    .owner      (grant)
  );

  // Nothing is granted while reset is asserted, so no access leaks out.
  assign owner       = rst_n ? grant : OWN_NONE;
  assign i_req_ready = (owner == OWN_I);
  assign d_req_ready = (owner == OWN_D);

  always_comb begin
    mem_en    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    case (owner)
      OWN_I: begin
        mem_en   = 1'b1;
        mem_addr = i_req_addr;
        mem_be   = 4'b1111;
      end
      OWN_D: begin
        mem_en    = 1'b1;
        mem_addr  = d_req_addr;
        mem_wdata = d_req_wdata;
        mem_we    = d_req_we;
        mem_be    = d_req_be;
      end
      default: ;
    endcase
  end

  // The state register is the response-valid flag; read data comes straight
  // from memory since it only arrives in the response cycle. Gating with
  // rst_n drops a pending response as soon as reset is asserted.
  assign i_rsp_valid = rst_n && (state == RESP_I);
  assign d_rsp_valid = rst_n && (state == RESP_D);
  assign i_rsp_data  = i_rsp_valid ? mem_rdata : '0;
  assign d_rsp_data  = (d_rsp_valid && !d_was_write) ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      d_was_write <= 1'b0;
    end else begin
      case (owner)
        OWN_I:   state <= RESP_I;
        OWN_D:   state <= RESP_D;
        default: state <= IDLE;
      endcase

      if (owner == OWN_D) begin
        d_was_write <= d_req_we;
      end

      if (owner == OWN_I) begin
        starve_cnt <= '0;
      end else if (i_req_valid && (starve_cnt != CNT_W'(MAX_STARVE))) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        i_req_valid;
  logic [31:0] i_req_addr;
  logic        i_req_ready;
  logic        i_rsp_valid;
  logic [31:0] i_rsp_data;
  logic        d_req_valid;
  logic [31:0] d_req_addr;
  logic [31:0] d_req_wdata;
  logic        d_req_we;
  logic [3:0]  d_req_be;
  logic        d_req_ready;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_data;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;

  int n_checks;
  int n_pass;

  mem_arbiter #(.MAX_STARVE(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req_valid (i_req_valid),
    .i_req_addr  (i_req_addr),
    .i_req_ready (i_req_ready),
    .i_rsp_valid (i_rsp_valid),
    .i_rsp_data  (i_rsp_data),
    .d_req_valid (d_req_valid),
    .d_req_addr  (d_req_addr),
    .d_req_wdata (d_req_wdata),
    .d_req_we    (d_req_we),
    .d_req_be    (d_req_be),
    .d_req_ready (d_req_ready),
    .d_rsp_valid (d_rsp_valid),
    .d_rsp_data  (d_rsp_data),
    .mem_en      (mem_en),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_be      (mem_be),
    .mem_rdata   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model contents: one fixed instruction word, otherwise address-tagged.
  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'h0000_0004) return 32'h0050_0093;
    return {a[15:0], 16'hC0DE};
  endfunction

  // Reads return rom() next cycle; writes return junk that must never reach a response.
  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= rom(mem_addr);
    else if (mem_en)       mem_rdata <= 32'hBAD0_BAD0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    mem_rdata   = '0;
    rst_n       = 1'b0;
    i_req_valid = 1'b1;
    i_req_addr  = 32'h10;
    d_req_valid = 1'b1;
    d_req_addr  = 32'h20;
    d_req_wdata = '0;
    d_req_we    = 1'b0;
    d_req_be    = 4'hF;

    // Reset with both valids asserted: nothing may be granted.
    tick();
    tick();
    check("rst_i_ready", 32'(i_req_ready), 32'd0);
    check("rst_d_ready", 32'(d_req_ready), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_i_rsp", 32'(i_rsp_valid), 32'd0);
    check("rst_d_rsp", 32'(d_rsp_valid), 32'd0);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    check("rst_starve", 32'(dut.starve_cnt), 32'd0);
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    rst_n       = 1'b1;
    tick();
    check("idle_mem_en", 32'(mem_en), 32'd0);
    check("idle_mem_addr", mem_addr, 32'd0);

    // Single fetch.
    i_req_valid = 1'b1;
    i_req_addr  = 32'h4;
    #1;
    check("f_ready", 32'(i_req_ready), 32'd1);
    check("f_mem_en", 32'(mem_en), 32'd1);
    check("f_mem_addr", mem_addr, 32'h4);
    check("f_mem_we", 32'(mem_we), 32'd0);
    check("f_mem_be", 32'(mem_be), 32'hF);
    tick();
    i_req_valid = 1'b0;
    #1;
    check("f_rsp_valid", 32'(i_rsp_valid), 32'd1);
    check("f_rsp_data", i_rsp_data, 32'h0050_0093);
    check("f_d_rsp", 32'(d_rsp_valid), 32'd0);
    check("f_mem_en_off", 32'(mem_en), 32'd0);
    tick();
    check("f_rsp_end", 32'(i_rsp_valid), 32'd0);

    // Data write.
    d_req_valid = 1'b1;
    d_req_addr  = 32'h100;
    d_req_wdata = 32'hDEAD_BEEF;
    d_req_we    = 1'b1;
    d_req_be    = 4'b0011;
    #1;
    check("w_ready", 32'(d_req_ready), 32'd1);
    check("w_i_ready", 32'(i_req_ready), 32'd0);
    check("w_mem_addr", mem_addr, 32'h100);
    check("w_mem_we", 32'(mem_we), 32'd1);
    check("w_mem_be", 32'(mem_be), 32'h3);
    check("w_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick();
    // A data read is accepted in the same cycle as the write ack.
    d_req_addr  = 32'h200;
    d_req_we    = 1'b0;
    d_req_be    = 4'hF;
    #1;
    check("w_rsp_valid", 32'(d_rsp_valid), 32'd1);
    check("w_rsp_data", d_rsp_data, 32'd0);
    check("w_i_rsp", 32'(i_rsp_valid), 32'd0);
    check("r_ready", 32'(d_req_ready), 32'd1);
    check("r_mem_we", 32'(mem_we), 32'd0);
    tick();
    d_req_valid = 1'b0;
    #1;
    check("r_rsp_valid", 32'(d_rsp_valid), 32'd1);
    check("r_rsp_data", d_rsp_data, 32'h0200_C0DE);
    tick();
    check("r_rsp_end", 32'(d_rsp_valid), 32'd0);

    // Back-to-back fetches 0x0, 0x4, 0x8.
    for (int k = 0; k < 3; k++) begin
      i_req_valid = 1'b1;
      i_req_addr  = 32'(4 * k);
      #1;
      check($sformatf("b2b_ready%0d", k), 32'(i_req_ready), 32'd1);
      if (k > 0) begin
        check($sformatf("b2b_rsp%0d", k - 1), 32'(i_rsp_valid), 32'd1);
        check($sformatf("b2b_data%0d", k - 1), i_rsp_data, rom(32'(4 * (k - 1))));
      end
      tick();
    end
    i_req_valid = 1'b0;
    #1;
    check("b2b_rsp2", 32'(i_rsp_valid), 32'd1);
    check("b2b_data2", i_rsp_data, 32'h0008_C0DE);
    tick();
    check("b2b_end", 32'(i_rsp_valid), 32'd0);

    // Contention: D,D,D,D,I repeating with starvation counter 0..4.
    i_req_valid = 1'b1;
    i_req_addr  = 32'h40;
    d_req_valid = 1'b1;
    d_req_addr  = 32'h300;
    d_req_we    = 1'b0;
    for (int n = 0; n < 10; n++) begin
      #1;
      check($sformatf("arb_i_ready%0d", n), 32'(i_req_ready), 32'((n % 5) == 4));
      check($sformatf("arb_d_ready%0d", n), 32'(d_req_ready), 32'((n % 5) != 4));
      check($sformatf("arb_starve%0d", n), 32'(dut.starve_cnt), 32'(n % 5));
      if (n > 0) begin
        check($sformatf("arb_i_rsp%0d", n), 32'(i_rsp_valid), 32'(((n - 1) % 5) == 4));
        check($sformatf("arb_d_rsp%0d", n), 32'(d_rsp_valid), 32'(((n - 1) % 5) != 4));
      end
      tick();
    end
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    #1;
    check("arb_starve_end", 32'(dut.starve_cnt), 32'd0);
    check("arb_last_i_rsp", 32'(i_rsp_valid), 32'd1);
    check("arb_last_data", i_rsp_data, 32'h0040_C0DE);
    tick();

    // Fetch pulsed for one cycle while data wins, then withdrawn.
    i_req_valid = 1'b1;
    i_req_addr  = 32'h80;
    d_req_valid = 1'b1;
    d_req_addr  = 32'h400;
    d_req_we    = 1'b1;
    d_req_wdata = 32'h1234_5678;
    #1;
    check("wd_i_ready", 32'(i_req_ready), 32'd0);
    check("wd_d_ready", 32'(d_req_ready), 32'd1);
    check("wd_mem_addr", mem_addr, 32'h400);
    tick();
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    #1;
    check("wd_starve", 32'(dut.starve_cnt), 32'd1);
    check("wd_mem_en", 32'(mem_en), 32'd0);
    check("wd_i_rsp", 32'(i_rsp_valid), 32'd0);
    tick();
    check("wd_i_rsp2", 32'(i_rsp_valid), 32'd0);
    check("wd_starve_hold", 32'(dut.starve_cnt), 32'd1);

    // Reset in the cycle after a data accept.
    d_req_valid = 1'b1;
    d_req_addr  = 32'h500;
    d_req_we    = 1'b0;
    #1;
    check("mr_accept", 32'(d_req_ready), 32'd1);
    tick();
    rst_n       = 1'b0;
    i_req_valid = 1'b1;
    #1;
    check("mr_d_rsp", 32'(d_rsp_valid), 32'd0);
    check("mr_i_ready", 32'(i_req_ready), 32'd0);
    check("mr_d_ready", 32'(d_req_ready), 32'd0);
    check("mr_mem_en", 32'(mem_en), 32'd0);
    tick();
    check("mr_state", 32'(dut.state), 32'(IDLE));
    check("mr_starve", 32'(dut.starve_cnt), 32'd0);
    check("mr_d_rsp2", 32'(d_rsp_valid), 32'd0);
    rst_n       = 1'b1;
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    tick();
    check("mr_d_rsp3", 32'(d_rsp_valid), 32'd0);
    check("mr_i_rsp3", 32'(i_rsp_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
